// File: rtl/ubadma_pkg.sv
// Shared definitions for the UBA DMA sequencer: FSM states, pager flag
// bit positions and KS10 address bit numbering helpers.
package ubadma_pkg;

    localparam int ADDR_W = 36;
    localparam int GID_W  = 3;

    // pageFLAGS bit positions
    localparam int FLG_RPW = 0;
    localparam int FLG_E16 = 1;
    localparam int FLG_FTM = 2;
    localparam int FLG_VLD = 3;

    // KS10 bit number of address bit A17 (bits numbered 0 = MSB .. 35 = LSB)
    localparam int A17 = 18;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XLATE = 3'd1,
        ST_REQ   = 3'd2,
        ST_DONE  = 3'd3,
        ST_NXM   = 3'd4
    } state_t;

    // KS10 numbers bits from the MSB; vectors here are [35:0], so convert.
    function automatic int ks10_bit(input int n);
        return ADDR_W - 1 - n;
    endfunction

endpackage

// File: rtl/uba_rr_arb.sv
// Combinational round-robin picker: first requester at or after the
// pointer, wrapping N-1 -> 0. The pointer register lives in the parent.
module uba_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    // Walk the request vector starting at the pointer; the first hit wins.
    always_comb begin
        int k;
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(i_ptr) + i;
            if (k >= N) k = k - N;
            if (!o_vld && i_req[k]) begin
                o_vld    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/uba_dma_sched.sv
// UBA DMA sequencer: round-robin grant among NDEV devices, page check of the
// granted address, KS10 bus request with timeout, then a one-cycle ACK or
// NXM pulse back to the granted device.
module uba_dma_sched
    import ubadma_pkg::*;
#(
    parameter int NDEV    = 4,
    parameter int TOWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NDEV-1:0]        devREQ,
    input  logic [NDEV*ADDR_W-1:0] devADDR,
    output logic [ADDR_W-1:0]      pageADDRI,
    input  logic [3:0]             pageFLAGS,
    output logic                   busREQO,
    input  logic                   busACKI,
    output logic [NDEV-1:0]        devACKO,
    output logic [NDEV-1:0]        devNXMO,
    output logic                   nxmSET,
    output logic [GID_W-1:0]       grantID
);

    // Timeout fires on the cycle the counter would reach all-ones, which
    // keeps busREQO high for exactly 2**TOWIDTH-1 cycles.
    localparam logic [TOWIDTH-1:0] CNT_LAST = {{(TOWIDTH-1){1'b1}}, 1'b0};

    state_t              r_state;
    logic [GID_W-1:0]    r_rrptr;
    logic [TOWIDTH-1:0]  r_cnt;

    logic [NDEV-1:0]     w_gnt;
    logic [GID_W-1:0]    w_idx;
    logic                w_vld;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [NDEV-1:0]     w_gid_oh;
    logic                w_xlate_bad;
    logic                w_unused_flags;

    uba_rr_arb #(
        .N  (NDEV),
        .IW (GID_W)
    ) u_arb (
        .i_req (devREQ),
        .i_ptr (r_rrptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

    // Address of the device the arbiter is currently picking.
    always_comb begin
        w_sel_addr = '0;
        for (int n = 0; n < NDEV; n++) begin
            if (w_gnt[n]) w_sel_addr = devADDR[ADDR_W*n +: ADDR_W];
        end
    end

    // One-hot of the latched grant, used for the ACK/NXM pulse.
    always_comb begin
        w_gid_oh = '0;
        for (int n = 0; n < NDEV; n++) begin
            w_gid_oh[n] = (grantID == GID_W'(n));
        end
    end

    // Only VLD and A17 decide the outcome; the other flags pass through.
    assign w_xlate_bad    = !pageFLAGS[FLG_VLD] || pageADDRI[ks10_bit(A17)];
    assign w_unused_flags = ^{pageFLAGS[FLG_RPW], pageFLAGS[FLG_E16], pageFLAGS[FLG_FTM]};

    // Transfer sequencer: grant, translate, bus request, report outcome.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_rrptr   <= '0;
            r_cnt     <= '0;
            grantID   <= '0;
            pageADDRI <= '0;
            busREQO   <= 1'b0;
            devACKO   <= '0;
            devNXMO   <= '0;
            nxmSET    <= 1'b0;
        end else begin
            devACKO <= '0;
            devNXMO <= '0;
            nxmSET  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_vld) begin
                        grantID   <= w_idx;
                        pageADDRI <= w_sel_addr;
                        r_rrptr   <= (w_idx == GID_W'(NDEV - 1)) ? '0 : w_idx + GID_W'(1);
                        r_state   <= ST_XLATE;
                    end
                end
                ST_XLATE: begin
                    if (w_xlate_bad) begin
                        devNXMO <= w_gid_oh;
                        nxmSET  <= 1'b1;
                        r_state <= ST_NXM;
                    end else begin
                        busREQO <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + TOWIDTH'(1);
                    if (busACKI) begin
                        busREQO <= 1'b0;
                        devACKO <= w_gid_oh;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        busREQO <= 1'b0;
                        devNXMO <= w_gid_oh;
                        nxmSET  <= 1'b1;
                        r_state <= ST_NXM;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_NXM:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uba_dma_sched.sv
// Directed bench for uba_dma_sched: single transfer, round-robin order,
// translation failures, bus timeout, ack on the timeout cycle, mid-transfer reset.
module tb_uba_dma_sched;

    localparam int NDEV    = 4;
    localparam int TOWIDTH = 4;

    logic              clk;
    logic              rst;
    logic [NDEV-1:0]   devREQ;
    logic [NDEV*36-1:0] devADDR;
    logic [35:0]       pageADDRI;
    logic [3:0]        pageFLAGS;
    logic              busREQO;
    logic              busACKI;
    logic [NDEV-1:0]   devACKO;
    logic [NDEV-1:0]   devNXMO;
    logic              nxmSET;
    logic [2:0]        grantID;

    int n_assert = 0;
    int n_fail   = 0;

    // Device addresses: a2 has A17 (weight 0x20000) set, the others do not.
    localparam logic [35:0] A0 = 36'h000040000;
    localparam logic [35:0] A1 = 36'h000011234;
    localparam logic [35:0] A2 = 36'h800020000;
    localparam logic [35:0] A3 = 36'h7ABC40000;

    uba_dma_sched #(
        .NDEV    (NDEV),
        .TOWIDTH (TOWIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .devREQ    (devREQ),
        .devADDR   (devADDR),
        .pageADDRI (pageADDRI),
        .pageFLAGS (pageFLAGS),
        .busREQO   (busREQO),
        .busACKI   (busACKI),
        .devACKO   (devACKO),
        .devNXMO   (devNXMO),
        .nxmSET    (nxmSET),
        .grantID   (grantID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int hi;
        int guard;
        logic [3:0] exp_oh;

        rst       = 1'b0;
        devREQ    = '0;
        busACKI   = 1'b0;
        pageFLAGS = 4'b0000;
        devADDR   = {A3, A2, A1, A0};
        tick(); tick();

        // Reset state
        chk("rst_busREQO", 64'(busREQO), 64'd0);
        chk("rst_devACKO", 64'(devACKO), 64'd0);
        chk("rst_devNXMO", 64'(devNXMO), 64'd0);
        chk("rst_nxmSET",  64'(nxmSET),  64'd0);
        chk("rst_grantID", 64'(grantID), 64'd0);
        chk("rst_pageADDRI", 64'(pageADDRI), 64'd0);
        rst = 1'b1;
        tick();

        // Single device, ack after 3 busREQO cycles; early ack must be ignored
        pageFLAGS = 4'b1000;
        devREQ    = 4'b0001;
        busACKI   = 1'b1;
        tick();
        chk("t1_grantID", 64'(grantID), 64'd0);
        chk("t1_pageADDRI", 64'(pageADDRI), 64'(A0));
        chk("t1_req_xlate", 64'(busREQO), 64'd0);
        chk("t1_ack_ignored", 64'(devACKO), 64'd0);
        busACKI = 1'b0;
        tick();
        chk("t1_req_c1", 64'(busREQO), 64'd1);
        tick();
        chk("t1_req_c2", 64'(busREQO), 64'd1);
        tick();
        chk("t1_req_c3", 64'(busREQO), 64'd1);
        busACKI = 1'b1;
        tick();
        chk("t1_req_low", 64'(busREQO), 64'd0);
        chk("t1_devACKO", 64'(devACKO), 64'b0001);
        chk("t1_devNXMO", 64'(devNXMO), 64'd0);
        busACKI = 1'b0;
        devREQ  = '0;
        tick();
        chk("t1_ack_1cyc", 64'(devACKO), 64'd0);

        // Round-robin from a fresh pointer: 0,1,2,3,0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        devREQ = 4'b1111;
        pageFLAGS = 4'b1000;
        devADDR = {A3, A0, A1, A0}; // keep A17 clear for every device here
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            tick();
            chk($sformatf("rr%0d_grantID", k), 64'(grantID), 64'(k % 4));
            tick();
            chk($sformatf("rr%0d_busREQO", k), 64'(busREQO), 64'd1);
            busACKI = 1'b1;
            tick();
            chk($sformatf("rr%0d_devACKO", k), 64'(devACKO), 64'(exp_oh));
            busACKI = 1'b0;
            tick();
            chk($sformatf("rr%0d_ack_clr", k), 64'(devACKO), 64'd0);
            if (k == 4) devREQ = '0;
        end
        devADDR = {A3, A2, A1, A0};

        // Invalid page on device 1 (pointer now 1)
        pageFLAGS = 4'b0111;
        devREQ = 4'b0010;
        tick();
        chk("t3_grantID", 64'(grantID), 64'd1);
        chk("t3_req_xlate", 64'(busREQO), 64'd0);
        tick();
        chk("t3_devNXMO", 64'(devNXMO), 64'b0010);
        chk("t3_nxmSET", 64'(nxmSET), 64'd1);
        chk("t3_busREQO", 64'(busREQO), 64'd0);
        chk("t3_devACKO", 64'(devACKO), 64'd0);
        devREQ = '0;
        tick();
        chk("t3_nxm_clr", 64'(devNXMO), 64'd0);
        chk("t3_nxmset_clr", 64'(nxmSET), 64'd0);
        chk("t3_busREQO_idle", 64'(busREQO), 64'd0);

        // A17 set on device 2 with VLD=1
        pageFLAGS = 4'b1000;
        devREQ = 4'b0100;
        tick();
        chk("t4_grantID", 64'(grantID), 64'd2);
        chk("t4_pageADDRI", 64'(pageADDRI), 64'(A2));
        tick();
        chk("t4_devNXMO", 64'(devNXMO), 64'b0100);
        chk("t4_nxmSET", 64'(nxmSET), 64'd1);
        chk("t4_busREQO", 64'(busREQO), 64'd0);
        devREQ = '0;
        tick();

        // Timeout on device 3: 15 request cycles then NXM
        devREQ = 4'b1000;
        tick();
        chk("t5_grantID", 64'(grantID), 64'd3);
        hi = 0;
        guard = 0;
        while (devNXMO == '0 && devACKO == '0 && guard < 40) begin
            tick();
            guard++;
            if (busREQO) hi++;
        end
        chk("t5_no_timeout_hang", 64'(guard < 40), 64'd1);
        chk("t5_req_cycles", 64'(hi), 64'd15);
        chk("t5_devNXMO", 64'(devNXMO), 64'b1000);
        chk("t5_nxmSET", 64'(nxmSET), 64'd1);
        chk("t5_devACKO", 64'(devACKO), 64'd0);
        devREQ = '0;
        tick();

        // Ack on the 15th request cycle wins over timeout (device 0)
        devREQ = 4'b0001;
        tick();
        chk("t5b_grantID", 64'(grantID), 64'd0);
        hi = 0;
        guard = 0;
        while (devNXMO == '0 && devACKO == '0 && guard < 40) begin
            tick();
            guard++;
            if (busREQO) hi++;
            busACKI = (hi == 15) && busREQO;
        end
        busACKI = 1'b0;
        chk("t5b_no_hang", 64'(guard < 40), 64'd1);
        chk("t5b_req_cycles", 64'(hi), 64'd15);
        chk("t5b_devACKO", 64'(devACKO), 64'b0001);
        chk("t5b_devNXMO", 64'(devNXMO), 64'd0);
        chk("t5b_nxmSET", 64'(nxmSET), 64'd0);
        devREQ = '0;
        tick();

        // Reset in the middle of a bus request
        devREQ = 4'b0100;
        devADDR = {A3, A0, A1, A0};
        tick();
        tick();
        chk("t6_busREQO_pre", 64'(busREQO), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_busREQO_async", 64'(busREQO), 64'd0);
        chk("t6_grantID_rst", 64'(grantID), 64'd0);
        tick();
        chk("t6_no_ack", 64'(devACKO), 64'd0);
        chk("t6_no_nxm", 64'(devNXMO), 64'd0);
        rst = 1'b1;
        tick();
        chk("t6_regrant", 64'(grantID), 64'd2);
        chk("t6_pageADDRI", 64'(pageADDRI), 64'(A0));
        tick();
        chk("t6_busREQO_again", 64'(busREQO), 64'd1);
        busACKI = 1'b1;
        tick();
        chk("t6_devACKO", 64'(devACKO), 64'b0100);
        busACKI = 1'b0;
        devREQ = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
